dist_sample_checker: RTL and testbench
======================================

DIST_SAMPLE_CHECKER -- requirements
Module: dist_sample_checker

Interface
REQ-001 SHALL have parameter WINDOW, default 16, number of samples per measurement window (legal 1..256).
REQ-002 SHALL have parameter SUM_W, default 40, width of the signed sum accumulator.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start_in  input  1  one-cycle request to open a window; honoured only in IDLE.
REQ-006 SHALL have port lo_in  input  32  signed int lower bound, latched on accepted start.
REQ-007 SHALL have port hi_in  input  32  signed int upper bound, latched on accepted start.
REQ-008 SHALL have port sample_valid_in  input  1  sample_in is valid this cycle.
REQ-009 SHALL have port sample_in  input  32  signed int sample from a distribution source.
REQ-010 SHALL have port sample_ready_out  output  1  block accepts a sample this cycle.
REQ-011 SHALL have port report_valid_out  output  1  report fields valid.
REQ-012 SHALL have port report_ready_in  input  1  consumer takes report.
REQ-013 SHALL have port sum_out  output  SUM_W  signed sum of window samples.
REQ-014 SHALL have port min_out  output  32  signed minimum of window samples.
REQ-015 SHALL have port max_out  output  32  signed maximum of window samples.
REQ-016 SHALL have port oor_count_out  output  9  count of samples outside [lo, hi].
REQ-017 SHALL have port busy_out  output  1  high in COLLECT or REPORT.

Function
REQ-018 SHALL implement FSM states IDLE, COLLECT, REPORT.
REQ-019 IDLE: sample_ready_out=0, report_valid_out=0; start_in=1 -> latch lo_in/hi_in, clear sum/oor/sample counter, go COLLECT next cycle.
REQ-020 COLLECT: sample_ready_out=1; a sample is accepted on any cycle with sample_valid_in=1 and sample_ready_out=1.
REQ-021 On each accept: sum += sign-extended sample; oor +1 if sample < lo or sample > hi (signed compare).
REQ-022 First accepted sample of a window SHALL load both min and max; later samples update them by signed compare.
REQ-023 On the WINDOW-th accept, state SHALL go REPORT next cycle; report_valid_out asserts that cycle (latency 1 after final accept), with that final sample included.
REQ-024 REPORT: sample_ready_out=0; report fields SHALL hold stable while report_valid_out=1 and report_ready_in=0.
REQ-025 REPORT with report_ready_in=1 -> IDLE next cycle; report_valid_out deasserts then.
REQ-026 start_in in COLLECT or REPORT SHALL be ignored (no relatch, no clear).
REQ-027 start_in and report_ready_in in same REPORT cycle -> IDLE only; a new start requires a later IDLE cycle.
REQ-028 lo > hi SHALL be legal; every sample then counts as out-of-range.
REQ-029 Samples equal to lo or hi SHALL be in range.
REQ-030 sum arithmetic SHALL be two's complement in SUM_W bits (no saturation; no overflow for legal WINDOW at default SUM_W).
REQ-031 sample_valid_in outside COLLECT SHALL have no effect.
REQ-032 busy_out SHALL be a registered decode of state (1 in COLLECT, REPORT).

Reset
REQ-033 rst_n=0 SHALL force, asynchronously: state IDLE, sample_ready_out=0, report_valid_out=0, busy_out=0, sum_out=0, min_out=0, max_out=0, oor_count_out=0, latched bounds=0.
REQ-034 Reset asserted mid-COLLECT or mid-REPORT SHALL discard the partial window; after release the block waits in IDLE for start_in.

Verification
REQ-035 WINDOW=4, lo=0, hi=10, samples 3,-2,10,11 back-to-back -> report_valid 1 cycle after 4th accept; sum=22, min=-2, max=11, oor=2.
REQ-036 Same window, sample_valid_in gapped (valid every 3rd cycle) -> identical report; no sample accepted in IDLE/REPORT.
REQ-037 report_ready_in held 0 for 5 cycles in REPORT, sample_valid_in=1 throughout -> fields stable, sample_ready_out=0, then ready=1 -> IDLE next cycle.
REQ-038 lo=5, hi=-5, samples 0,5,-5,100 -> oor=4; sum=100, min=-5, max=100.
REQ-039 rst_n pulsed low after 2 accepts -> all outputs 0 immediately; new start with samples 1,1,1,1 -> sum=4, oor per new bounds, no residue.
REQ-040 start_in pulsed during COLLECT with new bounds -> ignored; oor computed against original bounds.

Source files
------------

// File: rtl/dist_sample_checker.sv
// dist_sample_checker
//   Collects a window of WINDOW signed 32-bit samples and reports the
//   window's signed sum, minimum, maximum and the number of samples that
//   fall outside the inclusive range [lo, hi] latched when the window opens.
//
// Ports
//   clk              in   single clock, rising edge
//   rst_n            in   asynchronous active-low reset
//   start_in         in   request to open a window (only honoured in IDLE)
//   lo_in, hi_in     in   signed range bounds, latched on accepted start
//   sample_valid_in  in   sample_in carries a sample this cycle
//   sample_in        in   signed sample
//   sample_ready_out out  block accepts a sample this cycle (COLLECT)
//   report_valid_out out  report fields valid (REPORT)
//   report_ready_in  in   consumer takes the report
//   sum_out          out  signed sum of the window samples (SUM_W bits)
//   min_out, max_out out  signed min / max of the window samples
//   oor_count_out    out  count of samples outside [lo, hi]
//   busy_out         out  registered: high in COLLECT or REPORT
module dist_sample_checker #(
    parameter int WINDOW = 16,
    parameter int SUM_W  = 40
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_in,
    input  logic [31:0]      lo_in,
    input  logic [31:0]      hi_in,
    input  logic             sample_valid_in,
    input  logic [31:0]      sample_in,
    output logic             sample_ready_out,
    output logic             report_valid_out,
    input  logic             report_ready_in,
    output logic [SUM_W-1:0] sum_out,
    output logic [31:0]      min_out,
    output logic [31:0]      max_out,
    output logic [8:0]       oor_count_out,
    output logic             busy_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        REPORT  = 2'd2
    } state_t;

    localparam logic [8:0] LAST_IDX = 9'(WINDOW - 1);

    state_t          state;
    state_t          next_state;
    logic [31:0]     lo_q;
    logic [31:0]     hi_q;
    logic [8:0]      count;
    logic            accept;
    logic            last_accept;
    logic            out_of_range;
    logic [SUM_W-1:0] sample_ext;

    // Casting a signed operand to a wider size sign-extends it.
    assign sample_ext   = SUM_W'($signed(sample_in));
    assign accept       = sample_valid_in && sample_ready_out;
    assign last_accept  = accept && (count == LAST_IDX);
    assign out_of_range = ($signed(sample_in) < $signed(lo_q)) ||
                          ($signed(sample_in) > $signed(hi_q));

    // State register; busy tracks the state it is entering so it is a
    // registered decode that changes on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy_out <= 1'b0;
        end else begin
            state    <= next_state;
            busy_out <= (next_state != IDLE);
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start_in)        next_state = COLLECT;
            COLLECT: if (last_accept)     next_state = REPORT;
            REPORT:  if (report_ready_in) next_state = IDLE;
            default:                      next_state = IDLE;
        endcase
    end

    always_comb begin
        sample_ready_out = 1'b0;
        report_valid_out = 1'b0;
        unique case (state)
            COLLECT: sample_ready_out = 1'b1;
            REPORT:  report_valid_out = 1'b1;
            default: ;
        endcase
    end

    // Window datapath: accumulators are the report fields themselves, so
    // they naturally hold stable through REPORT (no accepts there).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_q          <= '0;
            hi_q          <= '0;
            count         <= '0;
            sum_out       <= '0;
            min_out       <= '0;
            max_out       <= '0;
            oor_count_out <= '0;
        end else if (state == IDLE && start_in) begin
            lo_q          <= lo_in;
            hi_q          <= hi_in;
            count         <= '0;
            sum_out       <= '0;
            oor_count_out <= '0;
        end else if (accept) begin
            count   <= count + 9'd1;
            sum_out <= sum_out + sample_ext;
            if (out_of_range) begin
                oor_count_out <= oor_count_out + 9'd1;
            end
            if (count == '0) begin
                min_out <= sample_in;
                max_out <= sample_in;
            end else begin
                if ($signed(sample_in) < $signed(min_out)) begin
                    min_out <= sample_in;
                end
                if ($signed(sample_in) > $signed(max_out)) begin
                    max_out <= sample_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_dist_sample_checker.sv
// Directed bench for dist_sample_checker with WINDOW=4.
module tb_dist_sample_checker;

    localparam int SUM_W = 40;

    logic             clk;
    logic             rst_n;
    logic             start_in;
    logic [31:0]      lo_in;
    logic [31:0]      hi_in;
    logic             sample_valid_in;
    logic [31:0]      sample_in;
    logic             sample_ready_out;
    logic             report_valid_out;
    logic             report_ready_in;
    logic [SUM_W-1:0] sum_out;
    logic [31:0]      min_out;
    logic [31:0]      max_out;
    logic [8:0]       oor_count_out;
    logic             busy_out;

    int checks;
    int failures;

    dist_sample_checker #(.WINDOW(4), .SUM_W(SUM_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_in         (start_in),
        .lo_in            (lo_in),
        .hi_in            (hi_in),
        .sample_valid_in  (sample_valid_in),
        .sample_in        (sample_in),
        .sample_ready_out (sample_ready_out),
        .report_valid_out (report_valid_out),
        .report_ready_in  (report_ready_in),
        .sum_out          (sum_out),
        .min_out          (min_out),
        .max_out          (max_out),
        .oor_count_out    (oor_count_out),
        .busy_out         (busy_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic open_window(input int lo, input int hi);
        start_in = 1'b1;
        lo_in    = lo;
        hi_in    = hi;
        tick();
        start_in = 1'b0;
    endtask

    task automatic send(input int v);
        sample_valid_in = 1'b1;
        sample_in       = v;
        tick();
        sample_valid_in = 1'b0;
    endtask

    task automatic check_report(input string tag, input longint s, input int mn,
                                input int mx, input int oor);
        check({tag, "_valid"}, 64'(report_valid_out), 1);
        check({tag, "_sum"},   64'($signed(sum_out)), s);
        check({tag, "_min"},   64'($signed(min_out)), mn);
        check({tag, "_max"},   64'($signed(max_out)), mx);
        check({tag, "_oor"},   64'(oor_count_out), oor);
        check({tag, "_ready"}, 64'(sample_ready_out), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 64'(sample_ready_out), 0);
        check({tag, "_valid"}, 64'(report_valid_out), 0);
        check({tag, "_busy"},  64'(busy_out), 0);
        check({tag, "_sum"},   64'($signed(sum_out)), 0);
        check({tag, "_min"},   64'($signed(min_out)), 0);
        check({tag, "_max"},   64'($signed(max_out)), 0);
        check({tag, "_oor"},   64'(oor_count_out), 0);
    endtask

    task automatic take_report(input string tag);
        report_ready_in = 1'b1;
        tick();
        report_ready_in = 1'b0;
        check({tag, "_valid_drop"}, 64'(report_valid_out), 0);
        check({tag, "_busy_drop"},  64'(busy_out), 0);
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        rst_n           = 1'b0;
        start_in        = 1'b0;
        lo_in           = '0;
        hi_in           = '0;
        sample_valid_in = 1'b0;
        sample_in       = '0;
        report_ready_in = 1'b0;

        // Reset state
        #2;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check("idle_ready", 64'(sample_ready_out), 0);
        check("idle_busy",  64'(busy_out), 0);

        // Back-to-back window: 3,-2,10,11 in [0,10]
        open_window(0, 10);
        check("collect_busy",  64'(busy_out), 1);
        check("collect_ready", 64'(sample_ready_out), 1);
        send(3);
        send(-2);
        send(10);
        check("b2b_not_yet", 64'(report_valid_out), 0);
        send(11);
        check_report("b2b", 22, -2, 11, 2);
        check("b2b_busy", 64'(busy_out), 1);

        // Consumer stalls 5 cycles while samples keep arriving
        sample_valid_in = 1'b1;
        sample_in       = 32'd99;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_report("stall", 22, -2, 11, 2);
        end
        take_report("stall");

        // Samples offered in IDLE must not leak into the next window
        tick();
        tick();
        sample_valid_in = 1'b0;

        // Gapped window: valid every 3rd cycle
        open_window(0, 10);
        sample_valid_in = 1'b0; tick(); tick(); send(3);
        sample_valid_in = 1'b0; tick(); tick(); send(-2);
        sample_valid_in = 1'b0; tick(); tick(); send(10);
        sample_valid_in = 1'b0; tick(); tick();
        check("gap_not_yet", 64'(report_valid_out), 0);
        send(11);
        check_report("gap", 22, -2, 11, 2);

        // start together with report_ready in REPORT: return to IDLE only
        start_in        = 1'b1;
        lo_in           = 100;
        hi_in           = 200;
        report_ready_in = 1'b1;
        tick();
        start_in        = 1'b0;
        report_ready_in = 1'b0;
        check("sr_valid", 64'(report_valid_out), 0);
        check("sr_busy",  64'(busy_out), 0);
        tick();
        check("sr_still_idle", 64'(busy_out), 0);
        check("sr_no_ready",   64'(sample_ready_out), 0);

        // Inverted bounds: everything out of range, equal-to-bound too
        open_window(5, -5);
        send(0);
        send(5);
        send(-5);
        send(100);
        check_report("inv", 100, -5, 100, 4);
        take_report("inv");

        // start during COLLECT with new bounds is ignored
        open_window(0, 10);
        send(3);
        start_in        = 1'b1;
        lo_in           = -100;
        hi_in           = 100;
        send(-2);
        start_in        = 1'b0;
        send(10);
        check("ign_not_yet", 64'(report_valid_out), 0);
        send(11);
        check_report("ign", 22, -2, 11, 2);
        take_report("ign");

        // Reset mid-COLLECT discards the partial window
        open_window(0, 0);
        send(7);
        send(-9);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check("midrst_idle_busy", 64'(busy_out), 0);
        open_window(2, 5);
        send(1);
        send(1);
        send(1);
        send(1);
        check_report("post_rst", 4, 1, 1, 4);
        take_report("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
